// File: rtl/fma_elastic_pipe.sv
// fma_elastic_pipe: DEPTH-stage valid/ready register chain with bubble collapsing, optional skid, flush and occupancy
module fma_elastic_pipe #(
  parameter int DATA_W = 69,
  parameter int DEPTH  = 1,
  parameter int SKID   = 1,
  parameter int OCC_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [OCC_W-1:0]  occupancy
);
  logic [DEPTH-1:0]  v;
  logic [DEPTH-1:0]  pv;
  logic [DEPTH-1:0]  rdy;
  logic [DATA_W-1:0] d  [DEPTH];
  logic [DATA_W-1:0] pd [DEPTH];
  logic              skid_v;
  logic [DATA_W-1:0] skid_d;
  logic              in_xfer;
  logic              out_xfer;

  // A stage can load unless it and every stage after it are full while the output stalls.
  for (genvar k = 0; k < DEPTH; k++) begin : g_rdy
    assign rdy[k] = out_ready || !(&v[DEPTH-1:k]);
  end

  assign in_ready  = (SKID != 0) ? !skid_v : rdy[0];
  assign in_xfer   = in_valid && in_ready;
  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];
  assign out_xfer  = out_valid && out_ready;

  // Source of each stage: stage 0 prefers the skid entry, later stages take their predecessor.
  always_comb begin
    pv[0] = skid_v || in_valid;
    pd[0] = skid_v ? skid_d : in_data;
    for (int i = 1; i < DEPTH; i++) begin
      pv[i] = v[i-1];
      pd[i] = d[i-1];
    end
  end

  // Stage chain: shift where ready, data registers only load on a valid transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v <= '0;
      for (int i = 0; i < DEPTH; i++) d[i] <= '0;
    end else if (flush) begin
      v <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (rdy[i]) begin
          v[i] <= pv[i];
          if (pv[i]) d[i] <= pd[i];
        end
      end
    end
  end

  // Skid entry: captures an accepted input when stage 0 is blocked, drains once stage 0 frees up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_v <= 1'b0;
      skid_d <= '0;
    end else if (flush) begin
      skid_v <= 1'b0;
    end else if (skid_v) begin
      skid_v <= !rdy[0];
    end else if (SKID != 0 && in_valid && !rdy[0]) begin
      skid_v <= 1'b1;
      skid_d <= in_data;
    end
  end

  // Occupancy tracks accepted minus delivered entries; flush empties it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) occupancy <= '0;
    else if (flush) occupancy <= '0;
    else occupancy <= occupancy + OCC_W'(in_xfer) - OCC_W'(out_xfer);
  end
endmodule

// File: tb/tb_fma_elastic_pipe.sv
// tb_fma_elastic_pipe: directed and randomized scoreboard bench for fma_elastic_pipe
module tb_fma_elastic_pipe;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iv  [3];
  logic        ir  [3];
  logic        ov  [3];
  logic        orr [3];
  logic        fl  [3];
  logic [15:0] id  [3];
  logic [15:0] od  [3];
  logic [3:0]  oc  [3];
  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  fma_elastic_pipe #(.DATA_W(16), .DEPTH(3), .SKID(1), .OCC_W(4)) u_d3 (
    .clk(clk), .rst(rst), .flush(fl[0]), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]),
    .out_valid(ov[0]), .out_ready(orr[0]), .out_data(od[0]), .occupancy(oc[0]));
  fma_elastic_pipe #(.DATA_W(16), .DEPTH(4), .SKID(1), .OCC_W(4)) u_d4 (
    .clk(clk), .rst(rst), .flush(fl[1]), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]),
    .out_valid(ov[1]), .out_ready(orr[1]), .out_data(od[1]), .occupancy(oc[1]));
  fma_elastic_pipe #(.DATA_W(16), .DEPTH(1), .SKID(0), .OCC_W(4)) u_d1 (
    .clk(clk), .rst(rst), .flush(fl[2]), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(id[2]),
    .out_valid(ov[2]), .out_ready(orr[2]), .out_data(od[2]), .occupancy(oc[2]));

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_rand(input int u, input int n, input int depth, input int skid);
    logic [15:0] q[$];
    int sz;
    fl[u] = 1'b1;
    iv[u] = 1'b0;
    tick;
    fl[u] = 1'b0;
    for (int c = 0; c < n; c++) begin
      iv[u]  = ($urandom % 4) != 0;
      id[u]  = 16'($urandom);
      orr[u] = ($urandom % 3) != 0;
      fl[u]  = ($urandom % 30) == 0;
      #1;
      sz = q.size();
      check("rnd_occ", int'(oc[u]), sz);
      check("rnd_in_ready", int'(ir[u]), (skid != 0) ? int'(sz < depth + 1) : int'(orr[u] || sz < depth));
      if (sz == 0) check("rnd_ov_empty", int'(ov[u]), 0);
      if (ov[u] && orr[u] && sz > 0) begin
        check("rnd_data", int'(od[u]), int'(q[0]));
        void'(q.pop_front());
      end
      if (iv[u] && ir[u] && !fl[u]) q.push_back(id[u]);
      if (fl[u]) q.delete();
      tick;
    end
    iv[u]  = 1'b0;
    fl[u]  = 1'b0;
    orr[u] = 1'b1;
    for (int c = 0; c < 40 && q.size() > 0; c++) begin
      #1;
      if (ov[u]) begin
        check("drain_data", int'(od[u]), int'(q[0]));
        void'(q.pop_front());
      end
      tick;
    end
    check("drain_left", q.size(), 0);
    #1;
    check("drain_occ", int'(oc[u]), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int k;
    int e;
    for (int u = 0; u < 3; u++) begin
      iv[u] = 1'b0; orr[u] = 1'b0; fl[u] = 1'b0; id[u] = '0;
    end
    tick;
    tick;
    #1;
    check("rst_ov", int'(ov[0]), 0);
    check("rst_occ", int'(oc[0]), 0);
    check("rst_ir", int'(ir[0]), 1);
    check("rst_od", int'(od[0]), 0);
    rst = 1'b0;
    tick;
    // asynchronous reset mid-cycle with two entries held
    iv[0] = 1'b1; id[0] = 16'h11; tick;
    id[0] = 16'h22; tick;
    iv[0] = 1'b0;
    #1;
    check("prerst_occ", int'(oc[0]), 2);
    #2 rst = 1'b1;
    #1;
    check("arst_ov", int'(ov[0]), 0);
    check("arst_occ", int'(oc[0]), 0);
    check("arst_ir", int'(ir[0]), 1);
    #1 rst = 1'b0;
    tick;
    // streaming 1..10 through DEPTH=3
    orr[0] = 1'b1;
    for (int i = 0; i < 14; i++) begin
      iv[0] = i < 10;
      id[0] = 16'(i + 1);
      #1;
      if (i >= 3 && i < 13) begin
        check("stream_ov", int'(ov[0]), 1);
        check("stream_data", int'(od[0]), i - 2);
      end else check("stream_ov_idle", int'(ov[0]), 0);
      if (i >= 3 && i <= 10) check("stream_occ", int'(oc[0]), 3);
      tick;
    end
    // backpressure fill: 3 stages + skid
    orr[0] = 1'b0;
    k = 0;
    for (int i = 0; i < 7; i++) begin
      iv[0] = 1'b1;
      id[0] = 16'(16'hA1 + k);
      #1;
      if (ir[0]) k++;
      tick;
    end
    #1;
    check("bp_accepted", k, 4);
    check("bp_ir", int'(ir[0]), 0);
    check("bp_occ", int'(oc[0]), 4);
    orr[0] = 1'b1;
    e = 0;
    for (int i = 0; i < 12; i++) begin
      iv[0] = k < 5;
      id[0] = 16'(16'hA1 + k);
      #1;
      if (ov[0]) begin
        check("bp_data", int'(od[0]), 16'hA1 + e);
        e++;
      end
      if (iv[0] && ir[0]) k++;
      tick;
    end
    check("bp_delivered", e, 5);
    // bubble collapse in DEPTH=4
    orr[1] = 1'b0;
    iv[1] = 1'b1; id[1] = 16'h55; tick;
    iv[1] = 1'b0; tick; tick; tick;
    #1;
    check("bub_ov", int'(ov[1]), 1);
    check("bub_head", int'(od[1]), 16'h55);
    iv[1] = 1'b1; id[1] = 16'h66; tick;
    iv[1] = 1'b0; tick; tick;
    #1;
    check("bub_occ", int'(oc[1]), 2);
    check("bub_hold", int'(od[1]), 16'h55);
    check("bub_ir", int'(ir[1]), 1);
    orr[1] = 1'b1;
    tick;
    #1;
    check("bub_next_ov", int'(ov[1]), 1);
    check("bub_next", int'(od[1]), 16'h66);
    tick;
    #1;
    check("bub_empty_occ", int'(oc[1]), 0);
    // flush with simultaneous input
    orr[0] = 1'b0;
    iv[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      id[0] = 16'(16'h31 + i);
      tick;
    end
    id[0] = 16'h77;
    fl[0] = 1'b1;
    #1;
    check("flush_ir", int'(ir[0]), 1);
    tick;
    fl[0] = 1'b0;
    iv[0] = 1'b0;
    #1;
    check("flush_ov", int'(ov[0]), 0);
    check("flush_occ", int'(oc[0]), 0);
    orr[0] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick;
      #1;
      check("flush_no_out", int'(ov[0]), 0);
    end
    // SKID=0, DEPTH=1 combinational ready
    orr[2] = 1'b0;
    iv[2] = 1'b1; id[2] = 16'h90; tick;
    iv[2] = 1'b0;
    #1;
    check("s0_full_ir", int'(ir[2]), 0);
    check("s0_full_ov", int'(ov[2]), 1);
    orr[2] = 1'b1;
    #1;
    check("s0_comb_ir_hi", int'(ir[2]), 1);
    orr[2] = 1'b0;
    #1;
    check("s0_comb_ir_lo", int'(ir[2]), 0);
    orr[2] = 1'b1;
    iv[2] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      id[2] = 16'(16'h91 + i);
      #1;
      check("s0_ir", int'(ir[2]), 1);
      check("s0_ov", int'(ov[2]), 1);
      check("s0_occ", int'(oc[2]), 1);
      check("s0_data", int'(od[2]), 16'h90 + i);
      tick;
    end
    iv[2] = 1'b0;
    tick;
    // randomized scoreboard runs
    run_rand(0, 400, 3, 1);
    run_rand(1, 400, 4, 1);
    run_rand(2, 400, 1, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
